// File: rtl/eh2_posit_mul_iter.sv
// ==== eh2_posit_mul_iter : iterative shift-add posit multiplier core ====
// ==== rev 1.0 : initial release                                       ====
`default_nettype none

module eh2_posit_mul_iter #(
  parameter int POSIT_LEN   = 16,
  parameter int ES          = 2,
  parameter int REGIME_BW   = $clog2(POSIT_LEN),
  parameter int FRACTION_BW = POSIT_LEN - ES
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   valid_in,
  input  logic                   flush,
  input  logic                   rs1_sign,
  input  logic                   rs2_sign,
  input  logic [REGIME_BW-1:0]   rs1_regime,
  input  logic [REGIME_BW-1:0]   rs2_regime,
  input  logic [ES-1:0]          rs1_exponent,
  input  logic [ES-1:0]          rs2_exponent,
  input  logic [FRACTION_BW-1:0] rs1_fraction,
  input  logic [FRACTION_BW-1:0] rs2_fraction,
  input  logic                   is_special_rs1,
  input  logic                   is_special_rs2,
  output logic                   ready,
  output logic                   out_valid,
  output logic                   sign,
  output logic [REGIME_BW-1:0]   regime,
  output logic [ES-1:0]          exponent,
  output logic [FRACTION_BW-1:0] fraction,
  output logic                   is_oflw_or_uflw,
  output logic                   is_zero,
  output logic                   spec_rs1,
  output logic                   spec_rs2,
  output logic                   spec_sign1,
  output logic                   spec_sign2
);

  localparam int M        = FRACTION_BW + 1;
  localparam int SCALE_BW = REGIME_BW + ES + 2;
  localparam int CNT_BW   = $clog2(M + 1);
  localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_BW-1:0]     cnt;
  logic [2*M-1:0]        acc;
  logic [M-1:0]          mcand;
  logic [M-1:0]          mplier;
  logic                  sg1, sg2;
  logic [REGIME_BW-1:0]  rg1, rg2;
  logic [ES-1:0]         ex1, ex2;

  logic [2*M-1:0]        addend;
  logic [SCALE_BW-1:0]   scale1, scale2, scale_r;
  logic [SCALE_BW-ES-REGIME_BW:0] k_top;
  logic                  k_fits;

  assign addend = {{M{1'b0}}, mcand} << cnt;

  assign scale1  = ({{(SCALE_BW-REGIME_BW){rg1[REGIME_BW-1]}}, rg1} << ES)
                 + {{(SCALE_BW-ES){1'b0}}, ex1};
  assign scale2  = ({{(SCALE_BW-REGIME_BW){rg2[REGIME_BW-1]}}, rg2} << ES)
                 + {{(SCALE_BW-ES){1'b0}}, ex2};
  // product in [2,4) bumps the scale by one
  assign scale_r = scale1 + scale2 + {{(SCALE_BW-1){1'b0}}, acc[2*M-1]};

  // regime fits when every bit above the regime MSB matches it
  assign k_top  = scale_r[SCALE_BW-1:ES+REGIME_BW-1];
  assign k_fits = (&k_top) | ~(|k_top);

  assign ready   = (state == IDLE);
  assign is_zero = 1'b0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= IDLE;
      out_valid       <= 1'b0;
      cnt             <= '0;
      acc             <= '0;
      mcand           <= '0;
      mplier          <= '0;
      sg1             <= 1'b0;
      sg2             <= 1'b0;
      rg1             <= '0;
      rg2             <= '0;
      ex1             <= '0;
      ex2             <= '0;
      sign            <= 1'b0;
      regime          <= '0;
      exponent        <= '0;
      fraction        <= '0;
      is_oflw_or_uflw <= 1'b0;
      spec_rs1        <= 1'b0;
      spec_rs2        <= 1'b0;
      spec_sign1      <= 1'b0;
      spec_sign2      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            sg1    <= rs1_sign;
            sg2    <= rs2_sign;
            rg1    <= rs1_regime;
            rg2    <= rs2_regime;
            ex1    <= rs1_exponent;
            ex2    <= rs2_exponent;
            mcand  <= {1'b1, rs1_fraction};
            mplier <= {1'b1, rs2_fraction};
            acc    <= '0;
            cnt    <= '0;
            if (is_special_rs1 | is_special_rs2) begin
              state           <= DONE;
              out_valid       <= 1'b1;
              sign            <= rs1_sign ^ rs2_sign;
              regime          <= '0;
              exponent        <= '0;
              fraction        <= '0;
              is_oflw_or_uflw <= 1'b0;
              spec_rs1        <= is_special_rs1;
              spec_rs2        <= is_special_rs2;
              spec_sign1      <= rs1_sign;
              spec_sign2      <= rs2_sign;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (mplier[cnt]) begin
            acc <= acc + addend;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= NORM;
          end
        end
        NORM: begin
          state           <= DONE;
          out_valid       <= 1'b1;
          sign            <= sg1 ^ sg2;
          regime          <= scale_r[ES+REGIME_BW-1:ES];
          exponent        <= scale_r[ES-1:0];
          fraction        <= acc[2*M-1] ? acc[2*M-2 -: FRACTION_BW]
                                        : acc[2*M-3 -: FRACTION_BW];
          is_oflw_or_uflw <= ~k_fits;
          spec_rs1        <= 1'b0;
          spec_rs2        <= 1'b0;
          spec_sign1      <= sg1;
          spec_sign2      <= sg2;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eh2_posit_mul_iter.sv
// ==== tb_eh2_posit_mul_iter : self-checking bench for eh2_posit_mul_iter ====
// ==== rev 1.0 : initial release                                          ====
`default_nettype none

module tb_eh2_posit_mul_iter;

  localparam int ES = 2;
  localparam int RB = 4;
  localparam int FB = 14;
  localparam int M  = FB + 1;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          valid_in = 1'b0;
  logic          flush = 1'b0;
  logic          rs1_sign = 1'b0, rs2_sign = 1'b0;
  logic [RB-1:0] rs1_regime = '0, rs2_regime = '0;
  logic [ES-1:0] rs1_exponent = '0, rs2_exponent = '0;
  logic [FB-1:0] rs1_fraction = '0, rs2_fraction = '0;
  logic          is_special_rs1 = 1'b0, is_special_rs2 = 1'b0;

  logic          ready, out_valid, sign, is_oflw_or_uflw, is_zero;
  logic [RB-1:0] regime;
  logic [ES-1:0] exponent;
  logic [FB-1:0] fraction;
  logic          spec_rs1, spec_rs2, spec_sign1, spec_sign2;

  int checks = 0;
  int errors = 0;

  // expected outputs of the last completed operation
  logic [RB-1:0] last_k;
  logic [ES-1:0] last_e;
  logic [FB-1:0] last_f;

  eh2_posit_mul_iter dut (
    .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .flush(flush),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign),
    .rs1_regime(rs1_regime), .rs2_regime(rs2_regime),
    .rs1_exponent(rs1_exponent), .rs2_exponent(rs2_exponent),
    .rs1_fraction(rs1_fraction), .rs2_fraction(rs2_fraction),
    .is_special_rs1(is_special_rs1), .is_special_rs2(is_special_rs2),
    .ready(ready), .out_valid(out_valid), .sign(sign), .regime(regime),
    .exponent(exponent), .fraction(fraction),
    .is_oflw_or_uflw(is_oflw_or_uflw), .is_zero(is_zero),
    .spec_rs1(spec_rs1), .spec_rs2(spec_rs2),
    .spec_sign1(spec_sign1), .spec_sign2(spec_sign2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // value = (-1)^s * 2^(4k+e) * (1 + f/2^14); product normalised back to [1,2)
  task automatic model(output logic [RB-1:0] rk, output logic [ES-1:0] re,
                       output logic [FB-1:0] rf, output logic ro);
    longint p;
    int sc, ee, kk;
    if (is_special_rs1 || is_special_rs2) begin
      rk = '0; re = '0; rf = '0; ro = 1'b0;
      return;
    end
    p  = (longint'(rs1_fraction) + 16384) * (longint'(rs2_fraction) + 16384);
    sc = 4 * int'($signed(rs1_regime)) + int'(rs1_exponent)
       + 4 * int'($signed(rs2_regime)) + int'(rs2_exponent);
    if (p >= (longint'(1) << 29)) begin
      sc++;
      rf = FB'((p - (longint'(1) << 29)) >> 15);
    end else begin
      rf = FB'((p - (longint'(1) << 28)) >> 14);
    end
    ee = ((sc % 4) + 4) % 4;
    kk = (sc - ee) / 4;
    ro = (kk < -8) || (kk > 7);
    rk = RB'(kk);
    re = ES'(ee);
  endtask

  task automatic set_ops(input logic s1, input logic [RB-1:0] k1, input logic [ES-1:0] e1,
                         input logic [FB-1:0] f1, input logic sp1,
                         input logic s2, input logic [RB-1:0] k2, input logic [ES-1:0] e2,
                         input logic [FB-1:0] f2, input logic sp2);
    rs1_sign = s1; rs1_regime = k1; rs1_exponent = e1; rs1_fraction = f1; is_special_rs1 = sp1;
    rs2_sign = s2; rs2_regime = k2; rs2_exponent = e2; rs2_fraction = f2; is_special_rs2 = sp2;
  endtask

  // called at a negedge; accepts the current operands and checks the result
  task automatic run_op(input string tag);
    logic [RB-1:0] ek; logic [ES-1:0] ee; logic [FB-1:0] ef; logic eo;
    logic es1, es2, esp1, esp2;
    int n;
    model(ek, ee, ef, eo);
    es1 = rs1_sign; es2 = rs2_sign; esp1 = is_special_rs1; esp2 = is_special_rs2;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    n = 0;
    if (!(esp1 || esp2)) chk({tag, "_busy"}, {31'd0, ready}, 32'd0);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, (esp1 || esp2) ? 32'd0 : 32'(M + 1));
    chk({tag, "_sign"}, {31'd0, sign}, {31'd0, es1 ^ es2});
    chk({tag, "_oflw"}, {31'd0, is_oflw_or_uflw}, {31'd0, eo});
    if (!eo) begin
      chk({tag, "_regime"}, {28'd0, regime}, {28'd0, ek});
      chk({tag, "_exp"}, {30'd0, exponent}, {30'd0, ee});
      chk({tag, "_frac"}, {18'd0, fraction}, {18'd0, ef});
    end
    chk({tag, "_spec"}, {28'd0, spec_rs1, spec_rs2, spec_sign1, spec_sign2},
        {28'd0, esp1, esp2, es1, es2});
    chk({tag, "_zero"}, {31'd0, is_zero}, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, out_valid, ready}, 32'd1);
    last_k = ek; last_e = ee; last_f = ef;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready_valid", {30'd0, ready, out_valid}, 32'd2);
    chk("rst_results", {10'd0, sign, regime, exponent, fraction, is_oflw_or_uflw},
        32'd0);
    chk("rst_spec", {28'd0, spec_rs1, spec_rs2, spec_sign1, spec_sign2}, 32'd0);
    rst_l = 1'b1;
    @(negedge clk);

    // directed cases
    set_ops(0, 4'h0, 2'd0, 14'h0000, 0, 0, 4'h0, 2'd0, 14'h0000, 0); run_op("one_x_one");
    chk("one_x_one_frac_lit", {18'd0, fraction}, 32'h0);
    set_ops(0, 4'h0, 2'd0, 14'h2000, 0, 0, 4'h0, 2'd0, 14'h2000, 0); run_op("p15_x_p15");
    chk("p15_x_p15_lit", {14'd0, regime, exponent, fraction}, {14'd0, 4'h0, 2'd1, 14'h0800});
    set_ops(1, 4'hF, 2'd0, 14'h0000, 0, 0, 4'h0, 2'd0, 14'h0000, 0); run_op("neg_small");
    set_ops(0, 4'h7, 2'd3, 14'h0000, 0, 0, 4'h7, 2'd3, 14'h0000, 0); run_op("overflow");
    chk("overflow_flag", {31'd0, is_oflw_or_uflw}, 32'd1);
    set_ops(0, 4'h8, 2'd0, 14'h0000, 0, 0, 4'h8, 2'd0, 14'h0000, 0); run_op("underflow");
    set_ops(0, 4'h3, 2'd2, 14'h1234, 1, 1, 4'h2, 2'd1, 14'h0fff, 0); run_op("special1");
    set_ops(1, 4'h0, 2'd0, 14'h0000, 1, 0, 4'h0, 2'd0, 14'h0000, 1); run_op("special_both");

    // randomized operands
    for (int i = 0; i < 24; i++) begin
      set_ops(1'($urandom), 4'($urandom), 2'($urandom), 14'($urandom),
              ($urandom_range(0, 9) == 0),
              1'($urandom), 4'($urandom), 2'($urandom), 14'($urandom),
              ($urandom_range(0, 9) == 0));
      run_op("rand");
    end

    // known non-trivial previous result for the hold checks below
    set_ops(0, 4'h0, 2'd0, 14'h2000, 0, 0, 4'h0, 2'd0, 14'h2000, 0); run_op("pre_flush");

    // flush at cycle 5 of a multiply
    set_ops(0, 4'h1, 2'd1, 14'h3fff, 0, 1, 4'h2, 2'd2, 14'h1111, 0);
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", {30'd0, ready, out_valid}, 32'd2);
    chk("flush_hold", {14'd0, regime, exponent, fraction}, {14'd0, last_k, last_e, last_f});
    expect_quiet("flush_no_valid", M + 5);

    // flush beats accept
    flush = 1'b1; valid_in = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk("flush_vs_accept", {31'd0, ready}, 32'd1);
    expect_quiet("flush_vs_accept_quiet", M + 5);

    // valid_in while busy is dropped
    set_ops(0, 4'h0, 2'd0, 14'h2000, 0, 0, 4'h0, 2'd0, 14'h2000, 0);
    fork
      run_op("busy_ignore");
      begin
        repeat (3) @(negedge clk);
        set_ops(1, 4'h5, 2'd3, 14'h0001, 0, 1, 4'h6, 2'd2, 14'h0002, 1);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
      end
    join
    expect_quiet("busy_no_second", M + 5);

    // asynchronous reset at cycle 8
    set_ops(0, 4'h1, 2'd2, 14'h0abc, 0, 0, 4'h2, 2'd1, 14'h0123, 0);
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_ready_valid", {30'd0, ready, out_valid}, 32'd2);
    chk("arst_results", {10'd0, sign, regime, exponent, fraction, is_oflw_or_uflw}, 32'd0);
    chk("arst_spec", {28'd0, spec_rs1, spec_rs2, spec_sign1, spec_sign2}, 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    expect_quiet("arst_no_valid", M + 5);

    set_ops(1, 4'hE, 2'd3, 14'h3000, 0, 0, 4'h1, 2'd1, 14'h0555, 0); run_op("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
